tug_match_controller: RTL and testbench
=======================================

Name: tug_match_controller

Overview:
Sequences a best-of-N tug-of-war match around the existing 9-light chain and victory logic. Converts raw player keys into single-cycle, arbitrated pull pulses. Detects points from the chain's end lights, keeps per-player scores, and pauses between points. Drives the chain's reset so each point restarts from the centre light.

Parameters:
WIN_SCORE, 3, points needed to win the match (1..15)
HOLD_CYCLES, 4, cycles frozen in POINT state after a point is scored (>=1)
SCORE_W, 4, score counter width; must satisfy 2**SCORE_W > WIN_SCORE

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_l  input  1  left player key, already synchronised, active-high level
key_r  input  1  right player key, already synchronised, active-high level
new_match  input  1  level; starts a new match, honoured only in MATCH_OVER
led_pos  input  9  light chain state; bit 8 = leftmost, bit 0 = rightmost
chain_reset  output  1  drives the reset of the light chain and victory logic
pull_l  output  1  one-cycle pulse to the chain L input
pull_r  output  1  one-cycle pulse to the chain R input
score_l  output  SCORE_W  left player points
score_r  output  SCORE_W  right player points
winner  output  2  00 none, 10 left won, 01 right won
state_dbg  output  2  current FSM state encoding, for bench/LED observation

Behaviour:
- Reset is synchronous and active-high. Output values while reset is high and in the first cycle after it deasserts:
  - chain_reset=1, pull_l=pull_r=0, scores=0, winner=00.
  - Key-history registers are loaded with 1, so a key held through reset produces no pulse.
- States: CHAIN_RST=0, PLAY=1, POINT=2, MATCH_OVER=3. Reset forces CHAIN_RST.
- CHAIN_RST:
  - chain_reset=1 for exactly one cycle, then go to PLAY.
  - Key edges sampled in this cycle are discarded.
- Edge detect: rise_x = key_x & ~key_x_q. key_x_q updates every cycle in every state.
- PLAY, pulse generation (registered, latency 1):
  - A rise sampled at cycle t gives a pull pulse at t+1.
  - rise_l & ~rise_r -> pull_l. rise_r & ~rise_l -> pull_r.
  - Simultaneous rises cancel; no pulse.
  - A held key never repeats. At most one pull output is high in any cycle.
- Point detection, evaluated in PLAY:
  - Left point: pull_l==1 and led_pos[8]==1 in the same cycle. Right point: pull_r==1 and led_pos[0]==1.
  - On a point, at the next edge: the scorer's count increments, the state goes to POINT, and the hold counter loads HOLD_CYCLES-1.
  - No pull pulse is issued in the cycle after a point, even if a rise was sampled.
- POINT:
  - Pulses are suppressed and chain_reset=0; the chain keeps showing the end light for HOLD_CYCLES cycles.
  - When the counter reaches 0: if either score == WIN_SCORE, go to MATCH_OVER; otherwise go to CHAIN_RST.
- MATCH_OVER:
  - winner is set (10 or 01) on entry and held. Pulses are suppressed.
  - new_match==1 clears the scores and winner, then goes to CHAIN_RST. new_match is ignored in all other states.
- Scores saturate at WIN_SCORE and never wrap. Only one score can change per cycle.
- Reset asserted mid-match (in any state, including mid-hold) returns to the reset values at the next edge.
- led_pos with both bit 8 and bit 0 set is illegal. If it occurs, the pull direction decides the point.

Decomposition:
- Shared package tug_pkg holds:
  - state enum (CHAIN_RST, PLAY, POINT, MATCH_OVER)
  - winner encodings (WIN_NONE=2'b00, WIN_L=2'b10, WIN_R=2'b01)
  - NUM_LIGHTS=9, LEFT_END=8, RIGHT_END=0
- One sub-module: key_edge_arbiter.
  - Contains the two edge detectors, the tie-cancel logic and the registered pulse outputs, with an enable input.
  - Instantiated once. The FSM, scores and hold counter stay in the top module.

Test Plan:
- Reset with key_l held high, release reset -> chain_reset=1 for 1 cycle after reset, state PLAY, no pull_l pulse until key_l falls and rises again.
- key_l rises at cycle t -> pull_l=1 only at t+1. key_l held 10 cycles -> exactly one pulse. key_l and key_r rise in the same cycle -> no pulse on either output.
- Model the chain with led_pos[8]=1, issue a left rise -> score_l 0->1 the cycle after the pulse, then POINT for 4 cycles with no pulses despite key activity, then chain_reset for 1 cycle, then PLAY.
- Drive three left points with WIN_SCORE=3 -> score_l=3, winner=10, state MATCH_OVER. Further keys produce no pulses. new_match=1 -> scores 0, winner 00, CHAIN_RST.
- Alternate left and right points to reach 2-2, then a right point -> score_r=3, winner=01, score_l stays 2.
- Assert reset during POINT with hold counter at 2 -> next cycle scores 0, winner 00, chain_reset=1, and the hold is not resumed.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match controller.
// Light chain geometry and winner encodings live here.
package tug_pkg;

    typedef enum logic [1:0] {
        CHAIN_RST  = 2'd0,
        PLAY       = 2'd1,
        POINT      = 2'd2,
        MATCH_OVER = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b10;
    localparam logic [1:0] WIN_R    = 2'b01;

    localparam int NUM_LIGHTS = 9;
    localparam int LEFT_END   = 8;
    localparam int RIGHT_END  = 0;

endpackage

// File: rtl/tug_match_controller_if.sv
// Player, chain and score signals between the match controller and its
// surroundings; the controller takes the slave view.
interface tug_match_controller_if #(
    parameter int SCORE_W = 4
);
    import tug_pkg::*;

    logic                  key_l;
    logic                  key_r;
    logic                  new_match;
    logic [NUM_LIGHTS-1:0] led_pos;
    logic                  chain_reset;
    logic                  pull_l;
    logic                  pull_r;
    logic [SCORE_W-1:0]    score_l;
    logic [SCORE_W-1:0]    score_r;
    logic [1:0]            winner;
    logic [1:0]            state_dbg;

    modport master (
        output key_l, key_r, new_match, led_pos,
        input  chain_reset, pull_l, pull_r,
        input  score_l, score_r, winner, state_dbg
    );

    modport slave (
        input  key_l, key_r, new_match, led_pos,
        output chain_reset, pull_l, pull_r,
        output score_l, score_r, winner, state_dbg
    );

endinterface

// File: rtl/key_edge_arbiter.sv
// Rising-edge detection on both player keys with tie cancellation.
// Produces registered single-cycle pull pulses, gated by en.
module key_edge_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic key_l,
    input  logic key_r,
    output logic pull_l,
    output logic pull_r
);

    logic key_l_q;
    logic key_r_q;
    logic rise_l;
    logic rise_r;

    assign rise_l = key_l & ~key_l_q;
    assign rise_r = key_r & ~key_r_q;

    // History loads 1 so a key held through reset never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            key_l_q <= 1'b1;
            key_r_q <= 1'b1;
            pull_l  <= 1'b0;
            pull_r  <= 1'b0;
        end else begin
            key_l_q <= key_l;
            key_r_q <= key_r;
            pull_l  <= en & rise_l & ~rise_r;
            pull_r  <= en & rise_r & ~rise_l;
        end
    end

endmodule

// File: rtl/tug_match_controller.sv
// Best-of-N tug-of-war sequencer: arbitrated pulls, point detection,
// per-player scores, hold between points and match-over handling.
module tug_match_controller #(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 4
) (
    input logic clk,
    input logic reset,
    tug_match_controller_if.slave bus
);
    import tug_pkg::*;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    state_t             state;
    state_t             state_nxt;
    logic [HOLD_W-1:0]  hold;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [1:0]         winner;
    logic               pull_l;
    logic               pull_r;
    logic               point_l;
    logic               point_r;
    logic               point;
    logic               won;
    logic               arb_en;
    logic               chain_rst;

    assign point_l = (state == PLAY) & pull_l & bus.led_pos[LEFT_END];
    assign point_r = (state == PLAY) & pull_r & bus.led_pos[RIGHT_END];
    assign point   = point_l | point_r;
    assign won     = (score_l == WIN_VAL) | (score_r == WIN_VAL);

    key_edge_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .key_l  (bus.key_l),
        .key_r  (bus.key_r),
        .pull_l (pull_l),
        .pull_r (pull_r)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= CHAIN_RST;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CHAIN_RST:  state_nxt = PLAY;
            PLAY:       if (point) state_nxt = POINT;
            POINT: begin
                if (hold == '0)
                    state_nxt = won ? MATCH_OVER : CHAIN_RST;
            end
            MATCH_OVER: if (bus.new_match) state_nxt = CHAIN_RST;
            default:    state_nxt = CHAIN_RST;
        endcase
    end

    // The pull issued alongside a point must not be followed by another
    always_comb begin
        chain_rst = (state == CHAIN_RST);
        arb_en    = (state == PLAY) & ~point;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_l <= '0;
            score_r <= '0;
            winner  <= WIN_NONE;
            hold    <= '0;
        end else begin
            unique case (state)
                PLAY: begin
                    if (point) begin
                        hold <= HOLD_LOAD;
                        if (point_l) begin
                            if (score_l != WIN_VAL)
                                score_l <= score_l + SCORE_W'(1);
                        end else if (score_r != WIN_VAL) begin
                            score_r <= score_r + SCORE_W'(1);
                        end
                    end
                end
                POINT: begin
                    if (hold != '0)
                        hold <= hold - HOLD_W'(1);
                    else if (won)
                        winner <= (score_l == WIN_VAL) ? WIN_L : WIN_R;
                end
                MATCH_OVER: begin
                    if (bus.new_match) begin
                        score_l <= '0;
                        score_r <= '0;
                        winner  <= WIN_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.chain_reset = chain_rst;
    assign bus.pull_l      = pull_l;
    assign bus.pull_r      = pull_r;
    assign bus.score_l     = score_l;
    assign bus.score_r     = score_r;
    assign bus.winner      = winner;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_tug_match_controller.sv
// Vector table plus scripted point sequences for the match controller.
// Each applied row queues its expected post-edge outputs for comparison.
module tb_tug_match_controller;

    typedef struct {
        string      name;
        bit         rst;
        bit         kl;
        bit         kr;
        bit         nm;
        logic [8:0] led;
        bit         cr;
        bit         pl;
        bit         pr;
        logic [1:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] win;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t sb[$];
    vec_t tbl[$];

    tug_match_controller_if #(.SCORE_W(4)) bus ();

    tug_match_controller #(
        .WIN_SCORE   (3),
        .HOLD_CYCLES (4),
        .SCORE_W     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input string name, input bit rst, input bit kl, input bit kr,
        input bit nm, input logic [8:0] led, input bit cr, input bit pl,
        input bit pr, input int st, input int sl, input int sr,
        input logic [1:0] win);
        vec_t v;
        v.name = name; v.rst = rst; v.kl = kl; v.kr = kr; v.nm = nm;
        v.led = led; v.cr = cr; v.pl = pl; v.pr = pr;
        v.st = 2'(st); v.sl = 4'(sl); v.sr = 4'(sr); v.win = win;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        logic [14:0] act;
        logic [14:0] req;
        reset         = v.rst;
        bus.key_l     = v.kl;
        bus.key_r     = v.kr;
        bus.new_match = v.nm;
        bus.led_pos   = v.led;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        act = {bus.chain_reset, bus.pull_l, bus.pull_r, bus.state_dbg,
               bus.score_l, bus.score_r, bus.winner};
        req = {e.cr, e.pl, e.pr, e.st, e.sl, e.sr, e.win};
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got cr=%b pl=%b pr=%b st=%0d sl=%0d sr=%0d win=%b, want cr=%b pl=%b pr=%b st=%0d sl=%0d sr=%0d win=%b",
                     e.name, bus.chain_reset, bus.pull_l, bus.pull_r,
                     bus.state_dbg, bus.score_l, bus.score_r, bus.winner,
                     e.cr, e.pl, e.pr, e.st, e.sl, e.sr, e.win);
        end
    endtask

    // Scores sl/sr are the expected counts after this point is taken
    task automatic score_point(input bit left, input int sl, input int sr,
                               input bit fin, input logic [8:0] led);
        int psl;
        int psr;
        logic [1:0] w;
        psl = left ? sl - 1 : sl;
        psr = left ? sr : sr - 1;
        w   = fin ? (left ? 2'b10 : 2'b01) : 2'b00;
        apply(mk("pt_idle",   0, 0, 0, 0, led, 0, 0, 0, 1, psl, psr, 2'b00));
        apply(mk("pt_rise",   0, left, !left, 0, led,
                 0, left, !left, 1, psl, psr, 2'b00));
        apply(mk("pt_score",  0, 0, 0, 0, led, 0, 0, 0, 2, sl, sr, 2'b00));
        apply(mk("pt_hold_a", 0, 1, 1, 0, led, 0, 0, 0, 2, sl, sr, 2'b00));
        apply(mk("pt_hold_b", 0, 0, 0, 0, led, 0, 0, 0, 2, sl, sr, 2'b00));
        apply(mk("pt_hold_c", 0, 1, 0, 0, led, 0, 0, 0, 2, sl, sr, 2'b00));
        apply(mk("pt_end", 0, 0, 0, 0, 9'h000, !fin, 0, 0,
                 fin ? 3 : 0, sl, sr, w));
        if (!fin)
            apply(mk("pt_play", 0, 0, 0, 0, 9'h000, 0, 0, 0, 1, sl, sr, 2'b00));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.key_l = 1'b0;
        bus.key_r = 1'b0;
        bus.new_match = 1'b0;
        bus.led_pos = '0;

        tbl.push_back(mk("rst_hold",  1, 1, 0, 0, 9'h000, 1, 0, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mk("rst_rel",   0, 1, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("held_np",   0, 1, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("l_fall",    0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("l_rise",    0, 1, 0, 0, 9'h000, 0, 1, 0, 1, 0, 0, 2'b00));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk("l_held", 0, 1, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("l_rel",     0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("r_rise",    0, 0, 1, 0, 9'h000, 0, 0, 1, 1, 0, 0, 2'b00));
        tbl.push_back(mk("r_rel",     0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("tie_rise",  0, 1, 1, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("tie_hold",  0, 1, 1, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("both_rel",  0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("r_hold",    0, 0, 1, 0, 9'h000, 0, 0, 1, 1, 0, 0, 2'b00));
        tbl.push_back(mk("l_rise_rh", 0, 1, 1, 0, 9'h000, 0, 1, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("both_rel2", 0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("r_far_end", 0, 0, 1, 0, 9'h100, 0, 0, 1, 1, 0, 0, 2'b00));
        tbl.push_back(mk("no_r_pt",   0, 0, 0, 0, 9'h100, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("lp_rise",   0, 1, 0, 0, 9'h100, 0, 1, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk("lp_score",  0, 0, 1, 0, 9'h100, 0, 0, 0, 2, 1, 0, 2'b00));
        tbl.push_back(mk("hold_rise", 0, 1, 0, 0, 9'h100, 0, 0, 0, 2, 1, 0, 2'b00));
        tbl.push_back(mk("hold2",     0, 0, 0, 0, 9'h100, 0, 0, 0, 2, 1, 0, 2'b00));
        tbl.push_back(mk("hold3",     0, 1, 0, 0, 9'h100, 0, 0, 0, 2, 1, 0, 2'b00));
        tbl.push_back(mk("hold_end",  0, 0, 0, 0, 9'h100, 1, 0, 0, 0, 1, 0, 2'b00));
        tbl.push_back(mk("crst_rise", 0, 1, 0, 0, 9'h000, 0, 0, 0, 1, 1, 0, 2'b00));
        tbl.push_back(mk("crst_held", 0, 1, 0, 0, 9'h000, 0, 0, 0, 1, 1, 0, 2'b00));
        tbl.push_back(mk("idle",      0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 1, 0, 2'b00));
        tbl.push_back(mk("nm_ignored", 0, 0, 0, 1, 9'h000, 0, 0, 0, 1, 1, 0, 2'b00));

        foreach (tbl[i]) apply(tbl[i]);

        // Left sweeps to 3-0
        score_point(1'b1, 2, 0, 1'b0, 9'h100);
        score_point(1'b1, 3, 0, 1'b1, 9'h100);
        apply(mk("mo_key_l", 0, 1, 0, 0, 9'h000, 0, 0, 0, 3, 3, 0, 2'b10));
        apply(mk("mo_key_r", 0, 0, 1, 0, 9'h000, 0, 0, 0, 3, 3, 0, 2'b10));
        apply(mk("mo_new",   0, 0, 0, 1, 9'h000, 1, 0, 0, 0, 0, 0, 2'b00));
        apply(mk("mo_play",  0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));

        // Alternating to 2-2, right wins; right points see both end lights
        score_point(1'b1, 1, 0, 1'b0, 9'h100);
        score_point(1'b0, 1, 1, 1'b0, 9'h101);
        score_point(1'b1, 2, 1, 1'b0, 9'h100);
        score_point(1'b0, 2, 2, 1'b0, 9'h101);
        score_point(1'b0, 2, 3, 1'b1, 9'h101);
        apply(mk("mo2_key",  0, 1, 0, 0, 9'h000, 0, 0, 0, 3, 2, 3, 2'b01));
        apply(mk("mo2_new",  0, 0, 0, 1, 9'h000, 1, 0, 0, 0, 0, 0, 2'b00));
        apply(mk("mo2_play", 0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));

        // Reset lands two cycles into the hold
        apply(mk("rp_idle",    0, 0, 0, 0, 9'h100, 0, 0, 0, 1, 0, 0, 2'b00));
        apply(mk("rp_rise",    0, 1, 0, 0, 9'h100, 0, 1, 0, 1, 0, 0, 2'b00));
        apply(mk("rp_score",   0, 0, 0, 0, 9'h100, 0, 0, 0, 2, 1, 0, 2'b00));
        apply(mk("rp_hold",    0, 0, 0, 0, 9'h100, 0, 0, 0, 2, 1, 0, 2'b00));
        apply(mk("rp_reset",   1, 0, 0, 0, 9'h100, 1, 0, 0, 0, 0, 0, 2'b00));
        apply(mk("rp_release", 0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));
        apply(mk("rp_play",    0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 2'b00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
